// File: rtl/fill_memory_responder_if.sv
// rtl/fill_memory_responder_if.sv - request/response bundle between cache fill logic and memory responder
// Purpose: groups the fill request and read-response signals.
// Signals:
//   enable         request strobe, one request per cycle while high
//   wr             1 = write, 0 = read (meaningful only with enable)
//   address        byte address, bit 0 ignored
//   data_in        write data
//   data_out       read data, meaningful while data_valid is high
//   data_valid     one-cycle strobe per returned read
//   reads_inflight accepted reads not yet returned
// Modports: master = cache fill side, slave = memory responder.
interface fill_memory_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  enable;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [3:0]            reads_inflight;

  modport master (
    output enable, wr, address, data_in,
    input  data_out, data_valid, reads_inflight
  );

  modport slave (
    input  enable, wr, address, data_in,
    output data_out, data_valid, reads_inflight
  );
endinterface

// File: rtl/fill_memory_responder.sv
// rtl/fill_memory_responder.sv - fixed-latency pipelined word memory serving cache fill requests
// Purpose: accepts one read or write per cycle; reads return LATENCY cycles
// after the request cycle, in order, with a one-cycle data_valid strobe.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset (pipeline and counter only, not the array)
//   bus  fill_memory_responder_if.slave (enable/wr/address/data_in in,
//        data_out/data_valid/reads_inflight out)
module fill_memory_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int INDEX_BITS = 10,
  parameter int LATENCY    = 4
) (
  input logic                     clk,
  input logic                     rst,
  fill_memory_responder_if.slave  bus
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [INDEX_BITS-1:0] idx;
  logic                  rd_acc;
  logic                  wr_acc;

  // Byte lane bit and bits above the index are aliased away by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.address[ADDR_WIDTH-1:INDEX_BITS+1], bus.address[0]};

  assign idx    = bus.address[INDEX_BITS:1];
  assign wr_acc = bus.enable & bus.wr;
  assign rd_acc = bus.enable & ~bus.wr;

  // Word array: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[idx] <= bus.data_in;
    end
  end

  // Read pipeline; the last stage doubles as the output register.
  logic [LATENCY-1:0]    vld_q;
  logic [LATENCY-1:0]    vld_d;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [LATENCY];

  logic [3:0] inflight_q;
  logic [3:0] inflight_d;

  always_comb begin
    vld_d = '0;
    for (int k = 0; k < LATENCY; k++) begin
      dat_d[k] = dat_q[k];
    end
    // Array sampled at the accepting edge, so a later write cannot disturb it.
    vld_d[0] = rd_acc;
    if (rd_acc) begin
      dat_d[0] = mem_q[idx];
    end
    // Data only advances behind a valid token, so data_out holds between responses.
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        dat_d[k] = dat_q[k-1];
      end
    end
  end

  // Count drops at the edge that ends the data_valid cycle, so it peaks at LATENCY.
  always_comb begin
    inflight_d = inflight_q;
    case ({rd_acc, vld_q[LATENCY-1]})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      inflight_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      for (int k = 0; k < LATENCY; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign bus.data_out       = dat_q[LATENCY-1];
  assign bus.data_valid     = vld_q[LATENCY-1];
  assign bus.reads_inflight = inflight_q;

endmodule
